// File: rtl/switch_toggle_bank.sv
// Multi-channel debounced switch toggler: sync, stability-count debounce, polarity-selectable edge, toggle bit.
// Define SWITCH_TOGGLE_BANK_SYNC_EN for a two-flop input synchroniser (physical pins); otherwise one input register.
module switch_toggle_ch #(
  parameter int DEBOUNCE_LIMIT = 4,
  parameter int EDGE_MODE      = 0,
  parameter int CNT_W          = 3
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Switch,
  input  logic i_Toggle_Clr,
  output logic o_State,
  output logic o_Edge,
  output logic o_Toggle
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic             s;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             qual;

`ifdef SWITCH_TOGGLE_BANK_SYNC_EN
  logic meta;
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      meta <= 1'b0;
      s    <= 1'b0;
    end else begin
      meta <= i_Switch;
      s    <= meta;
    end
  end
`else
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) s <= 1'b0;
    else          s <= i_Switch;
  end
`endif

  assign accept = (s != o_State) && (cnt == CNT_LAST);

  // s is the level being accepted, so it gives the direction of the change
  always_comb begin
    qual = 1'b0;
    case (EDGE_MODE)
      0:       qual = accept & ~s;
      1:       qual = accept &  s;
      default: qual = accept;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt      <= '0;
      o_State  <= 1'b0;
      o_Edge   <= 1'b0;
      o_Toggle <= 1'b0;
    end else begin
      if (s == o_State)      cnt <= '0;
      else if (accept) begin
        cnt     <= '0;
        o_State <= s;
      end else               cnt <= cnt + CNT_W'(1);
      o_Edge <= qual;
      // clear has priority over a coincident toggle
      if (i_Toggle_Clr) o_Toggle <= 1'b0;
      else if (qual)    o_Toggle <= ~o_Toggle;
    end
  end
endmodule

module switch_toggle_bank #(
  parameter int NUM_CH         = 4,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int EDGE_MODE      = 0
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic [NUM_CH-1:0] i_Switch,
  input  logic [NUM_CH-1:0] i_Toggle_Clr,
  output logic [NUM_CH-1:0] o_State,
  output logic [NUM_CH-1:0] o_Edge,
  output logic [NUM_CH-1:0] o_Toggle
);
  localparam int CNT_W = $clog2(DEBOUNCE_LIMIT + 1);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    switch_toggle_ch #(
      .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
      .EDGE_MODE      (EDGE_MODE),
      .CNT_W          (CNT_W)
    ) u_ch (
      .i_Clk        (i_Clk),
      .i_Rst_n      (i_Rst_n),
      .i_Switch     (i_Switch[ch]),
      .i_Toggle_Clr (i_Toggle_Clr[ch]),
      .o_State      (o_State[ch]),
      .o_Edge       (o_Edge[ch]),
      .o_Toggle     (o_Toggle[ch])
    );
  end
endmodule

// File: tb/tb_switch_toggle_bank.sv
// Scoreboard bench: three 2-channel banks (edge modes 0, 2, 1), expected edge events queued at stimulus time.
module tb_switch_toggle_bank;
  localparam int LIM = 4;
`ifdef SWITCH_TOGGLE_BANK_SYNC_EN
  localparam int SYNC = 1;
`else
  localparam int SYNC = 0;
`endif
  localparam int LAT = LIM + SYNC;
  localparam int P   = LAT + 3;

  typedef struct { int cyc; logic [1:0] edg; logic [1:0] tog; logic [1:0] st; } exp_t;

  logic clk = 1'b0, rst_n = 1'b1;
  logic [1:0] sw_a = '0, clr_a = '0, sw_b = '0, clr_b = '0, sw_c = '0, clr_c = '0;
  logic [1:0] st_a, ed_a, tg_a, st_b, ed_b, tg_b, st_c, ed_c, tg_c;
  logic [1:0] ta;
  int cyc = 0, vecs = 0, errs = 0;
  exp_t q_a[$], q_b[$], q_c[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  switch_toggle_bank #(.NUM_CH(2), .DEBOUNCE_LIMIT(LIM), .EDGE_MODE(0)) dut_a (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Switch(sw_a), .i_Toggle_Clr(clr_a),
    .o_State(st_a), .o_Edge(ed_a), .o_Toggle(tg_a));
  switch_toggle_bank #(.NUM_CH(2), .DEBOUNCE_LIMIT(LIM), .EDGE_MODE(2)) dut_b (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Switch(sw_b), .i_Toggle_Clr(clr_b),
    .o_State(st_b), .o_Edge(ed_b), .o_Toggle(tg_b));
  switch_toggle_bank #(.NUM_CH(2), .DEBOUNCE_LIMIT(LIM), .EDGE_MODE(1)) dut_c (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Switch(sw_c), .i_Toggle_Clr(clr_c),
    .o_State(st_c), .o_Edge(ed_c), .o_Toggle(tg_c));

  // Edge-event scoreboards: every pulse must match the next queued event exactly
  always @(negedge clk) if (ed_a !== 2'b00) begin : mon_a
    exp_t e;
    vecs++;
    if (q_a.size() == 0) begin
      errs++; $display("FAIL mon_a unexpected edge=%b at cyc %0d, expected none", ed_a, cyc);
    end else begin
      e = q_a.pop_front();
      if (e.cyc !== cyc || e.edg !== ed_a || e.tog !== tg_a || e.st !== st_a) begin
        errs++;
        $display("FAIL mon_a got cyc=%0d edge=%b tog=%b st=%b, expected cyc=%0d edge=%b tog=%b st=%b",
                 cyc, ed_a, tg_a, st_a, e.cyc, e.edg, e.tog, e.st);
      end
    end
  end

  always @(negedge clk) if (ed_b !== 2'b00) begin : mon_b
    exp_t e;
    vecs++;
    if (q_b.size() == 0) begin
      errs++; $display("FAIL mon_b unexpected edge=%b at cyc %0d, expected none", ed_b, cyc);
    end else begin
      e = q_b.pop_front();
      if (e.cyc !== cyc || e.edg !== ed_b || e.tog !== tg_b || e.st !== st_b) begin
        errs++;
        $display("FAIL mon_b got cyc=%0d edge=%b tog=%b st=%b, expected cyc=%0d edge=%b tog=%b st=%b",
                 cyc, ed_b, tg_b, st_b, e.cyc, e.edg, e.tog, e.st);
      end
    end
  end

  always @(negedge clk) if (ed_c !== 2'b00) begin : mon_c
    exp_t e;
    vecs++;
    if (q_c.size() == 0) begin
      errs++; $display("FAIL mon_c unexpected edge=%b at cyc %0d, expected none", ed_c, cyc);
    end else begin
      e = q_c.pop_front();
      if (e.cyc !== cyc || e.edg !== ed_c || e.tog !== tg_c || e.st !== st_c) begin
        errs++;
        $display("FAIL mon_c got cyc=%0d edge=%b tog=%b st=%b, expected cyc=%0d edge=%b tog=%b st=%b",
                 cyc, ed_c, tg_c, st_c, e.cyc, e.edg, e.tog, e.st);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic at_neg(input int n);
    goto(n); @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    @(negedge clk);
    vecs++;
    if ({st_a, ed_a, tg_a, st_b, ed_b, tg_b, st_c, ed_c, tg_c} !== 18'b0) begin
      errs++; $display("FAIL reset_hold outputs a=%b/%b/%b c=%b/%b/%b, expected all 0",
                       st_a, ed_a, tg_a, st_c, ed_c, tg_c);
    end
    step(); rst_n = 1'b1;
    repeat (3) step();
    @(negedge clk);
    vecs++;
    if ({st_a, ed_a, tg_a, st_b, ed_b, tg_b, st_c, ed_c, tg_c} !== 18'b0) begin
      errs++; $display("FAIL reset_release outputs a=%b/%b/%b b=%b/%b/%b, expected all 0",
                       st_a, ed_a, tg_a, st_b, ed_b, tg_b);
    end
    ta = 2'b00;
  endtask

  task automatic test_basic();
    int d, d2;
    d = cyc + 1; goto(d); sw_a[0] = 1'b1;
    at_neg(d + LAT);
    vecs++;
    if (st_a !== 2'b00) begin
      errs++; $display("FAIL basic_early state=%b, expected 00", st_a);
    end
    at_neg(d + LAT + 1);
    vecs++;
    if (st_a !== 2'b01 || ed_a !== 2'b00 || tg_a !== 2'b00) begin
      errs++; $display("FAIL basic_rise st=%b edge=%b tog=%b, expected 01/00/00", st_a, ed_a, tg_a);
    end
    d2 = d + P; goto(d2); sw_a[0] = 1'b0;
    q_a.push_back('{cyc: d2 + 1 + LAT, edg: 2'b01, tog: 2'b01, st: 2'b00});
    ta = 2'b01;
    at_neg(d2 + 2 + LAT);
    vecs++;
    if (ed_a !== 2'b00 || tg_a !== 2'b01 || st_a !== 2'b00) begin
      errs++; $display("FAIL basic_after st=%b edge=%b tog=%b, expected 00/00/01", st_a, ed_a, tg_a);
    end
  endtask

  task automatic test_glitch();
    int d;
    d = cyc + 1; goto(d); sw_a[1] = 1'b1;
    goto(d + 3); sw_a[1] = 1'b0;
    repeat (LAT + 6) begin
      @(negedge clk);
      vecs++;
      if (st_a !== 2'b00 || tg_a !== ta) begin
        errs++; $display("FAIL glitch3 st=%b tog=%b at cyc %0d, expected 00/%b", st_a, tg_a, cyc, ta);
      end
    end
    d = cyc + 1; goto(d); sw_a[1] = 1'b1;
    goto(d + 4); sw_a[1] = 1'b0;
    q_a.push_back('{cyc: d + 5 + LAT, edg: 2'b10, tog: ta ^ 2'b10, st: 2'b00});
    ta = ta ^ 2'b10;
    at_neg(d + 1 + LAT);
    vecs++;
    if (st_a !== 2'b10 || ed_a !== 2'b00) begin
      errs++; $display("FAIL glitch4_accept st=%b edge=%b, expected 10/00", st_a, ed_a);
    end
    at_neg(d + 6 + LAT);
    vecs++;
    if (st_a !== 2'b00 || tg_a !== ta) begin
      errs++; $display("FAIL glitch4_release st=%b tog=%b, expected 00/%b", st_a, tg_a, ta);
    end
  endtask

  task automatic test_toggle_clr();
    int d;
    d = cyc + 1; goto(d); clr_a = 2'b01;
    goto(d + 1); clr_a = 2'b00;
    @(negedge clk);
    vecs++;
    if (tg_a !== 2'b10) begin
      errs++; $display("FAIL clr_ch0 tog=%b, expected 10", tg_a);
    end
    d = cyc + 1; goto(d); clr_a = 2'b10;
    goto(d + 1); clr_a = 2'b00;
    @(negedge clk);
    vecs++;
    if (tg_a !== 2'b00) begin
      errs++; $display("FAIL clr_ch1 tog=%b, expected 00", tg_a);
    end
    ta = 2'b00;
  endtask

  task automatic test_simultaneous();
    int d, d2;
    d = cyc + 1; goto(d); sw_a = 2'b11;
    d2 = d + P; goto(d2); sw_a = 2'b00;
    q_a.push_back('{cyc: d2 + 1 + LAT, edg: 2'b11, tog: 2'b11, st: 2'b00});
    ta = 2'b11;
    at_neg(d2 + 2 + LAT);
    vecs++;
    if (ed_a !== 2'b00 || tg_a !== 2'b11) begin
      errs++; $display("FAIL simul_after edge=%b tog=%b, expected 00/11", ed_a, tg_a);
    end
  endtask

  task automatic test_clr_coincide();
    int d, d2, acc;
    d = cyc + 1; goto(d); sw_a[0] = 1'b1;
    d2 = d + P; goto(d2); sw_a[0] = 1'b0;
    acc = d2 + 1 + LAT;
    q_a.push_back('{cyc: acc, edg: 2'b01, tog: 2'b10, st: 2'b00});
    goto(acc - 1); clr_a = 2'b01;
    goto(acc); clr_a = 2'b00;
    ta = 2'b10;
    at_neg(acc + 1);
    vecs++;
    if (tg_a !== 2'b10 || ed_a !== 2'b00 || st_a !== 2'b00) begin
      errs++; $display("FAIL clr_coincide st=%b edge=%b tog=%b, expected 00/00/10", st_a, ed_a, tg_a);
    end
  endtask

  task automatic test_mode2();
    int d;
    for (int r = 0; r < 2; r++) begin
      d = cyc + 1; goto(d); sw_b[0] = 1'b1;
      q_b.push_back('{cyc: d + 1 + LAT, edg: 2'b01, tog: 2'b01, st: 2'b01});
      goto(d + P); sw_b[0] = 1'b0;
      q_b.push_back('{cyc: d + P + 1 + LAT, edg: 2'b01, tog: 2'b00, st: 2'b00});
      goto(d + 2 * P);
    end
  endtask

  task automatic test_reset_mid_debounce();
    int d, r;
    d = cyc + 1; goto(d); sw_c[0] = 1'b1;
    q_c.push_back('{cyc: d + 1 + LAT, edg: 2'b01, tog: 2'b01, st: 2'b01});
    goto(d + P); sw_c[0] = 1'b0;
    at_neg(d + P + 1 + LAT);
    vecs++;
    if (st_c !== 2'b00 || tg_c !== 2'b01 || ed_c !== 2'b00) begin
      errs++; $display("FAIL mode1_release st=%b edge=%b tog=%b, expected 00/00/01", st_c, ed_c, tg_c);
    end
    d = cyc + 1; goto(d); sw_c[0] = 1'b1;
    goto(d + 3 + SYNC);
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({st_c, ed_c, tg_c} !== 6'b0 || tg_a !== 2'b00) begin
      errs++; $display("FAIL async_reset c=%b/%b/%b tog_a=%b, expected all 0", st_c, ed_c, tg_c, tg_a);
    end
    ta = 2'b00;
    goto(cyc + 2);
    r = cyc + 1; goto(r); rst_n = 1'b1;
    q_c.push_back('{cyc: r + 1 + LAT, edg: 2'b01, tog: 2'b01, st: 2'b01});
    at_neg(r + LAT);
    vecs++;
    if (ed_c !== 2'b00 || st_c !== 2'b00) begin
      errs++; $display("FAIL post_reset_early edge=%b st=%b, expected 00/00", ed_c, st_c);
    end
    at_neg(r + LAT + 2);
    vecs++;
    if (ed_c !== 2'b00 || tg_c !== 2'b01 || st_c !== 2'b01) begin
      errs++; $display("FAIL post_reset_after st=%b edge=%b tog=%b, expected 01/00/01", st_c, ed_c, tg_c);
    end
  endtask

  task automatic test_drain();
    repeat (P) step();
    vecs++;
    if (q_a.size() != 0) begin
      errs++; $display("FAIL drain_a pending=%0d, expected 0", q_a.size());
    end
    vecs++;
    if (q_b.size() != 0) begin
      errs++; $display("FAIL drain_b pending=%0d, expected 0", q_b.size());
    end
    vecs++;
    if (q_c.size() != 0) begin
      errs++; $display("FAIL drain_c pending=%0d, expected 0", q_c.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_toggle_clr();
    test_simultaneous();
    test_clr_coincide();
    test_mode2();
    test_reset_mid_debounce();
    test_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
